// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM state
// encoding and datapath select encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // States that wait on the memory port and are guarded by the timeout counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags when the count has
// reached MEM_TIMEOUT.
module mc_wait_timer #(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [TIMEOUT_W-1:0] count;

  // Saturating so an unobserved stall can never wrap back below the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TIMEOUT_W'(MEM_TIMEOUT))) begin
      count <= count + TIMEOUT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign timeout = (count == TIMEOUT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, bus timeout and
// trap state. Define MC_ADDI_EN to compile in the addi execution path.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       memto_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       retire,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
);

  state_t cur_state;
  logic   is_store;
  logic   waiting;
  logic   timeout;

  assign waiting = is_wait_state(cur_state);

  mc_wait_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!waiting || mem_ready),
    .enable (waiting && !mem_ready),
    .timeout(timeout)
  );

  // State sequencing, lw/sw class latch and sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= S_FETCH;
      is_store   <= 1'b0;
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (cur_state)
        S_FETCH: begin
          if (mem_ready) begin
            cur_state <= S_DECODE;
          end else if (timeout) begin
            cur_state <= S_TRAP;
            bus_err   <= 1'b1;
          end else begin
            cur_state <= S_FETCH;
          end
        end
        S_DECODE: begin
          is_store <= (opcode == OP_SW);
          case (opcode)
            OP_RTYPE:     cur_state <= S_R_EXEC;
            OP_LW, OP_SW: cur_state <= S_MEM_ADDR;
            OP_BEQ:       cur_state <= S_BRANCH;
            OP_J:         cur_state <= S_JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI:      cur_state <= S_ADDI_EXEC;
`endif
            default: begin
              cur_state  <= S_TRAP;
              illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: cur_state <= is_store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            cur_state <= (cur_state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
          end else if (timeout) begin
            cur_state <= S_TRAP;
            bus_err   <= 1'b1;
          end else begin
            cur_state <= cur_state;
          end
        end
        S_MEM_WB:    cur_state <= S_FETCH;
        S_R_EXEC:    cur_state <= S_R_WB;
        S_R_WB:      cur_state <= S_FETCH;
        S_BRANCH:    cur_state <= S_FETCH;
        S_JUMP:      cur_state <= S_FETCH;
`ifdef MC_ADDI_EN
        S_ADDI_EXEC: cur_state <= S_ADDI_WB;
        S_ADDI_WB:   cur_state <= S_FETCH;
`endif
        S_TRAP:      cur_state <= S_TRAP;
        default:     cur_state <= S_TRAP;
      endcase
    end
  end

  // Moore control decode; only FETCH loads and MEM_WR retire look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PC_SRC_ALU;
    retire        = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        retire    = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
        retire    = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
`endif
      default: retire = 1'b0;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised scoreboard bench for multicycle_control: a path-level model plans
// each instruction cycle by cycle; a negedge monitor checks every cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       memto_reg, reg_dst, reg_write, alu_src_a, retire, illegal_op, bus_err;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .memto_reg(memto_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .illegal_op(illegal_op),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic [5:0] op;
    logic       ill;
    logic       berr;
  } cyc_t;

  cyc_t plan[$];
  cyc_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic m_ill = 1'b0, m_berr = 1'b0, m_trapped = 1'b0;

  // Expected controls from the state-by-state output table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ret;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ret} = 11'b0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
      4'd5:  begin mwr = 1'b1; iod = 1'b1; ret = mr; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rdst = 1'b1; ret = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; ret = 1'b1; end
      4'd9:  begin pw = 1'b1; psrc = 2'b10; ret = 1'b1; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: begin rw = 1'b1; ret = 1'b1; end
      default: ret = 1'b0;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ret};
  endfunction

  // Monitor: every planned cycle is compared on the falling edge.
  always @(negedge clk) begin
    cyc_t e;
    logic [22:0] got, want;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got  = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
              retire, illegal_op, bus_err};
      want = {e.st, exp_ctrl(e.st, e.mr), e.ill, e.berr};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL cycle t=%0t state got %0d want %0d, ctrl+flags got %b want %b",
                 $time, got[22:19], want[22:19], got[18:0], want[18:0]);
      end
    end
  end

  task automatic add(input logic [3:0] st, input logic mr, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.mr = mr; c.op = op; c.ill = m_ill; c.berr = m_berr;
    plan.push_back(c);
  endtask

  task automatic add_any(input logic [3:0] st);
    add(st, 1'($urandom), 6'($urandom));
  endtask

  task automatic add_trap();
    m_trapped = 1'b1;
    repeat (3) add_any(4'd15);
  endtask

  // A memory wait phase: wt stalled cycles, then completion or a bus trap.
  task automatic wait_phase(input logic [3:0] st, input int wt, output logic ok);
    for (int i = 0; i < wt && i < 16; i++) add(st, 1'b0, 6'($urandom));
    if (wt >= 16) begin
      m_berr = 1'b1;
      add_trap();
      ok = 1'b0;
    end else begin
      add(st, 1'b1, 6'($urandom));
      ok = 1'b1;
    end
  endtask

  // Reference path of one instruction given its opcode and wait counts.
  task automatic gen(input logic [5:0] op, input int wf, input int wm);
    logic ok;
    wait_phase(4'd0, wf, ok);
    if (ok) begin
      add(4'd1, 1'($urandom), op);
      if (op == 6'd0) begin
        add_any(4'd6); add_any(4'd7);
      end else if (op == 6'd35) begin
        add_any(4'd2); wait_phase(4'd3, wm, ok);
        if (ok) add_any(4'd4);
      end else if (op == 6'd43) begin
        add_any(4'd2); wait_phase(4'd5, wm, ok);
      end else if (op == 6'd4) begin
        add_any(4'd8);
      end else if (op == 6'd2) begin
        add_any(4'd9);
`ifdef MC_ADDI_EN
      end else if (op == 6'd8) begin
        add_any(4'd10); add_any(4'd11);
`endif
      end else begin
        m_ill = 1'b1;
        add_trap();
      end
    end
  endtask

  task automatic do_reset();
    cyc_t c;
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    rst_n = 1'b0;
    m_ill = 1'b0; m_berr = 1'b0; m_trapped = 1'b0;
    c.st = 4'd0; c.mr = mem_ready; c.op = opcode; c.ill = 1'b0; c.berr = 1'b0;
    sb.push_back(c);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_plan(input int stop_at);
    int n;
    n = plan.size();
    if (stop_at >= 0 && stop_at < n) n = stop_at;
    for (int k = 0; k < n; k++) begin
      mem_ready = plan[k].mr;
      opcode    = plan[k].op;
      sb.push_back(plan[k]);
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  task automatic instr(input logic [5:0] op, input int wf, input int wm, input bit abort);
    gen(op, wf, wm);
    if (abort && plan.size() > 1) begin
      run_plan($urandom_range(1, plan.size() - 1));
      do_reset();
    end else begin
      run_plan(-1);
      if (m_trapped) do_reset();
    end
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 19) == 0) return $urandom_range(14, 17);
    return $urandom_range(0, 3);
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000100;
      3: return 6'b000010;
      4: return 6'b001000;
      5: return 6'($urandom);
      default: return 6'b000000;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    instr(6'b000000, 0, 0, 1'b0);
    instr(6'b100011, 0, 3, 1'b0);
    instr(6'b101011, 2, 0, 1'b0);
    instr(6'b000100, 0, 0, 1'b0);
    instr(6'b000010, 1, 0, 1'b0);
    instr(6'b111111, 0, 0, 1'b0);
    instr(6'b000000, 16, 0, 1'b0);
    instr(6'b000000, 15, 0, 1'b0);
    instr(6'b100011, 0, 15, 1'b0);
    instr(6'b101011, 0, 16, 1'b0);
    instr(6'b001000, 0, 0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      instr(pick_op(), pick_wait(), pick_wait(), ($urandom_range(0, 9) == 0));
    end
    @(negedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Multi-cycle MIPS controller: replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and write-back over several `clk` cycles.
- Drives the shared-memory multi-cycle datapath, which has one memory port, one ALU, and IR/MDR/A/B/ALUOut registers.
- Adds two things the single-cycle decoder lacks: a memory ready handshake with a bounded wait-timeout counter, and a trap state for illegal opcodes and bus timeouts.

## Interface
Parameters:
- `TIMEOUT_W`, 4: width of the memory wait counter.
- `MEM_TIMEOUT`, 15: maximum wait cycles with `mem_ready` low before a bus trap. Must be ≤ 2^`TIMEOUT_W`−1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]. Sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero.
- `i_or_d` out 1: memory address source, 0=PC, 1=ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR load.
- `memto_reg` out 1: write-back source, 1=MDR.
- `reg_dst` out 1: write-back destination, 1=rd.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A source, 0=PC, 1=A.
- `alu_src_b` out 2: ALU B source, 00=B, 01=4, 10=sign-extended immediate, 11=shifted sign-extended immediate.
- `alu_op` out 2: 00=add, 01=sub, 10=funct-decoded.
- `pc_source` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal_op` out 1: sticky, set in TRAP.
- `bus_err` out 1: sticky, set in TRAP.
- `state` out 4: current state (debug).

## Operation
Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=15.

- All control outputs are Moore-decoded from `state`. Exceptions: `ir_write` and `pc_write` in FETCH are additionally gated by `mem_ready`.
- Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - `mem_ready`=1 → DECODE.
- DECODE: `alu_src_b`=11, `alu_op`=00. Next state by `opcode`:
  - 000000 → R_EXEC
  - 100011, 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC (only when the macro is set)
  - anything else → TRAP with `illegal_op`=1.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - lw → MEM_RD; sw → MEM_WR. The opcode class is latched in DECODE.
- MEM_RD: `mem_read`=1, `i_or_d`=1. `mem_ready` → MEM_WB.
- MEM_WB: `reg_write`=1, `memto_reg`=1, `reg_dst`=0. → FETCH, `retire`=1.
- MEM_WR: `mem_write`=1, `i_or_d`=1. `mem_ready` → FETCH, `retire`=1.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1. → FETCH, `retire`=1.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. → FETCH, `retire`=1.
- JUMP: `pc_write`=1, `pc_source`=10. → FETCH, `retire`=1.
- ADDI_EXEC: as MEM_ADDR. → ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `memto_reg`=0. → FETCH, `retire`=1.
- `retire` is asserted combinationally in the final cycle of each instruction path.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states while `mem_ready`=0.
  - If `mem_ready`=0 while the counter equals `MEM_TIMEOUT` → TRAP with `bus_err`=1.
  - `mem_ready`=1 in the timeout cycle wins: the access completes normally.
- TRAP: all control outputs 0. Stays in TRAP until `rst_n`. `illegal_op` and `bus_err` hold their values.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `state`=FETCH, counter=0, `illegal_op`=0, `bus_err`=0.
  - Outputs therefore show FETCH decode: `mem_read`=1, `alu_src_b`=01, `ir_write`/`pc_write` follow `mem_ready`.
- Latency with zero waits:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - addi 4 cycles
  - beq 3 cycles
  - j 3 cycles
- Each wait cycle in FETCH/MEM_RD/MEM_WR adds one cycle. The maximum stall is `MEM_TIMEOUT` cycles; the trap is entered on the following edge.
- Reset asserted mid-instruction aborts immediately. No partial `reg_write` or `mem_write` is issued after the asynchronous reset edge.
- Reset deassertion is synchronised externally; the FSM leaves FETCH on the first edge with `mem_ready`=1.

## Configuration
- `MC_ADDI_EN` defined: ADDI_EXEC/ADDI_WB states are compiled in, and opcode 001000 executes as addi.
- `MC_ADDI_EN` undefined: the states are absent and 001000 traps with `illegal_op`=1.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - state encoding constants
  - ALU_OP and PC_SRC encodings
- One sub-module, `mc_wait_timer`: clear/enable inputs, `timeout` output, parametrised by `TIMEOUT_W`/`MEM_TIMEOUT`.

## Test plan
- Reset with `mem_ready`=1, opcode 000000 → state sequence 0,1,6,7,0; `reg_write`=1 and `reg_dst`=1 only in state 7; one `retire` pulse.
- lw (100011) with `mem_ready` low 3 cycles in MEM_RD → sequence 0,1,2,3,3,3,3,4,0; `memto_reg`=1 in state 4; total 8 cycles.
- beq (000100) → states 0,1,8; `pc_write_cond`=1, `alu_op`=01, `pc_source`=01 in state 8; `retire` in state 8.
- Opcode 111111 → TRAP (15), `illegal_op`=1, all controls 0; held until `rst_n` pulse, then FETCH and flags cleared.
- `mem_ready` held 0 in FETCH with default parameters → state 15 and `bus_err`=1 after 16 cycles. Separately, `mem_ready`=1 exactly on the 16th cycle → DECODE, no trap.
- opcode 001000 → with `MC_ADDI_EN`: states 0,1,10,11,0 with `alu_src_b`=10; without it: TRAP with `illegal_op`=1.
